ysyx_25020037_issue_ctrl: RTL
=============================

Name: ysyx_25020037_issue_ctrl

Overview:
- Issue scheduler between the IDU and the EXU.
- Keeps a per-register scoreboard of in-flight loads. ALU results are forwarded by the EXU bypass and are not tracked here.
- Stalls IDU→EXU issue on a load-use RAW hazard or on load capacity exhaustion.
- Runs a redirect/flush FSM that drops wrong-path instructions until the PC update is acknowledged.

Parameters:
- CNT_W, 2, width of each per-register pending-load counter; per-register max is 2^CNT_W−1.
- LOAD_DEPTH, 4, maximum total loads in flight (issued, not yet completed).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- idu_valid  input  1  IDU holds a decoded instruction
- idu_ready  output  1  instruction consumed by this block this cycle
- idu_rs1  input  5  source register 1
- idu_rs2  input  5  source register 2
- idu_rs1_used  input  1  rs1 is read
- idu_rs2_used  input  1  rs2 is read
- idu_rd  input  5  destination register
- idu_gpr_we  input  1  instruction writes rd
- idu_is_load  input  1  instruction is a load
- exu_ready  input  1  EXU can accept
- issue_valid  output  1  instruction forwarded to the EXU this cycle
- ld_done_valid  input  1  a load completed writeback
- ld_done_rd  input  5  rd of the completed load
- redirect_valid  input  1  EXU resolved a taken redirect
- redirect_ack  input  1  PC update performed (pc_updata)
- flushing  output  1  FSM is in FLUSH
- load_inflight  output  3  total loads in flight, range 0..LOAD_DEPTH
- sb_err  output  1  sticky: completion arrived for a register with count 0
- perf_stall_cnt  output  32  hazard stall cycles
- perf_flush_cnt  output  32  wrong-path instructions dropped

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- Reset state:
  - FSM = RUN, all 31 counters = 0, load_inflight = 0, sb_err = 0, perf counters = 0.
  - issue_valid = 0 and idu_ready = 0 while rst is high.
- Scoreboard: cnt[1..31], each CNT_W bits. x0 has no entry and is never a hazard.
- hazard, asserted when any of:
  - idu_rs1_used and rs1≠0 and cnt[rs1]≠0
  - idu_rs2_used and rs2≠0 and cnt[rs2]≠0
  - idu_is_load and idu_gpr_we and rd≠0, and either cnt[rd] is at max or load_inflight = LOAD_DEPTH
- RUN state, all combinational:
  - fire = idu_valid & exu_ready & ~hazard & ~redirect_valid
  - issue_valid = fire
  - idu_ready = exu_ready & ~hazard & ~redirect_valid
- FLUSH state, all combinational:
  - idu_ready = 1
  - issue_valid = 0
  - Each idu_valid cycle is a dropped wrong-path instruction.
- FSM transitions:
  - RUN→FLUSH on redirect_valid. No issue happens in that cycle.
  - FLUSH→RUN on redirect_ack. The first issue is allowed the following cycle.
  - redirect_valid while in FLUSH: stay in FLUSH.
  - redirect_ack while in RUN: ignored.
- Counter update, per register r, on each clock edge:
  - inc = fire & idu_is_load & idu_gpr_we & (idu_rd = r ≠ 0)
  - dec = ld_done_valid & (ld_done_rd = r ≠ 0) & cnt[r] ≠ 0
  - inc & dec in the same cycle: no change.
  - load_inflight follows the same inc/dec rule, with no wrap.
- Completion with cnt = 0: no counter change; sb_err is set and stays set until reset.
- A completing load clears its hazard in the same cycle for the next edge. An instruction stalled on rd issues one cycle after ld_done. Same-cycle bypass is not this block's job.
- In-flight loads are past the EXU and are never cancelled by FLUSH; completions continue to decrement during FLUSH.
- Non-load writers never touch the scoreboard.
- Asserting rst mid-operation clears all state immediately.

Optional Feature:
- Macro: YSYX_25020037_ISSUE_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with FSM = RUN & idu_valid & exu_ready & hazard & ~redirect_valid.
  - perf_flush_cnt increments each cycle with FSM = FLUSH & idu_valid.
  - Both counters wrap at 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load-use stall:
  - Stimulus: issue lw x5; next cycle add x6,x5,x1 with idu_valid=1, exu_ready=1; ld_done(x5) two cycles later.
  - Required: issue_valid=0 for 2 cycles, then 1 the cycle after ld_done. With PERF_EN, perf_stall_cnt=2.
- Capacity cap:
  - Stimulus: issue 4 loads to x1..x4, then a 5th load to x7.
  - Required: load_inflight=4; 5th stalls; one ld_done(x2) → 5th issues next cycle and load_inflight returns to 4.
- Per-register saturation (CNT_W=1):
  - Stimulus: issue lw x9, then lw x9 again.
  - Required: second lw stalls until ld_done(x9).
- Simultaneous inc/dec:
  - Stimulus: issue lw x3 in the same cycle as ld_done(x3) while cnt[x3]=1.
  - Required: cnt[x3] stays 1; load_inflight unchanged.
- Redirect:
  - Stimulus: redirect_valid pulse; 3 idu_valid cycles; redirect_ack.
  - Required: flushing=1 for those cycles; idu_ready=1 and issue_valid=0 throughout; perf_flush_cnt=3; RUN the cycle after ack.
- Spurious completion and reset:
  - Stimulus: ld_done(x10) with cnt=0.
  - Required: sb_err=1 and stays 1.
  - Stimulus: assert rst mid-FLUSH.
  - Required: flushing=0, sb_err=0, load_inflight=0 asynchronously.

Source files
------------

// File: rtl/ysyx_25020037_issue_ctrl.sv
// ysyx_25020037_issue_ctrl: IDU->EXU issue scheduler.
// Tracks in-flight loads per destination register, stalls issue on load-use
// hazards or when load capacity is exhausted, and drops wrong-path
// instructions while a redirect is pending.
// Optional performance counters are enabled with YSYX_25020037_ISSUE_PERF_EN.
module ysyx_25020037_issue_ctrl #(
    parameter int CNT_W      = 2,
    parameter int LOAD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idu_valid,
    output logic        idu_ready,
    input  logic [4:0]  idu_rs1,
    input  logic [4:0]  idu_rs2,
    input  logic        idu_rs1_used,
    input  logic        idu_rs2_used,
    input  logic [4:0]  idu_rd,
    input  logic        idu_gpr_we,
    input  logic        idu_is_load,
    input  logic        exu_ready,
    output logic        issue_valid,
    input  logic        ld_done_valid,
    input  logic [4:0]  ld_done_rd,
    input  logic        redirect_valid,
    input  logic        redirect_ack,
    output logic        flushing,
    output logic [2:0]  load_inflight,
    output logic        sb_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0]       DEPTH   = 3'(LOAD_DEPTH);

    state_t           state_q, state_d;
    // Entry 0 is never written, so x0 always reads as no pending load.
    logic [CNT_W-1:0] cnt_q [32];
    logic [2:0]       inflight_q;
    logic             sb_err_q;

    logic             hazard;
    logic             fire;
    logic             ld_inc;
    logic             done_hit;
    logic             spurious;

    // Hazard detection against the registered scoreboard.
    always_comb begin
        hazard = 1'b0;
        if (idu_rs1_used && (idu_rs1 != 5'd0) && (cnt_q[idu_rs1] != '0))
            hazard = 1'b1;
        if (idu_rs2_used && (idu_rs2 != 5'd0) && (cnt_q[idu_rs2] != '0))
            hazard = 1'b1;
        if (idu_is_load && idu_gpr_we && (idu_rd != 5'd0) &&
            ((cnt_q[idu_rd] == CNT_MAX) || (inflight_q == DEPTH)))
            hazard = 1'b1;
    end

    // FSM next state and handshake outputs; both handshakes held low in reset.
    always_comb begin
        state_d   = state_q;
        idu_ready = 1'b0;
        fire      = 1'b0;
        case (state_q)
            ST_RUN: begin
                idu_ready = exu_ready & ~hazard & ~redirect_valid;
                fire      = idu_valid & idu_ready;
                if (redirect_valid)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                idu_ready = 1'b1;
                // A fresh redirect keeps us flushing even if an ack arrives.
                if (redirect_ack && !redirect_valid)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            idu_ready = 1'b0;
            fire      = 1'b0;
        end
        issue_valid = fire;
    end

    // Scoreboard increment/decrement qualifiers.
    always_comb begin
        ld_inc   = fire & idu_is_load & idu_gpr_we & (idu_rd != 5'd0);
        done_hit = ld_done_valid & (ld_done_rd != 5'd0) & (cnt_q[ld_done_rd] != '0);
        spurious = ld_done_valid & ~done_hit;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // Per-register pending-load counters; simultaneous inc/dec cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < 32; r++)
                cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if ((ld_inc && (idu_rd == 5'(r))) &&
                    !(done_hit && (ld_done_rd == 5'(r))))
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (!(ld_inc && (idu_rd == 5'(r))) &&
                         (done_hit && (ld_done_rd == 5'(r))))
                    cnt_q[r] <= cnt_q[r] - 1'b1;
            end
        end
    end

    // Total in-flight loads and sticky spurious-completion flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            case ({ld_inc, done_hit})
                2'b10:   inflight_q <= inflight_q + 3'd1;
                2'b01:   inflight_q <= inflight_q - 3'd1;
                default: inflight_q <= inflight_q;
            endcase
            if (spurious)
                sb_err_q <= 1'b1;
        end
    end

    assign flushing      = (state_q == ST_FLUSH);
    assign load_inflight = inflight_q;
    assign sb_err        = sb_err_q;

`ifdef YSYX_25020037_ISSUE_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] drop_q;

    // Hazard-stall and wrong-path-drop cycle counters, free-running wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            if ((state_q == ST_RUN) && idu_valid && exu_ready && hazard && !redirect_valid)
                stall_q <= stall_q + 32'd1;
            if ((state_q == ST_FLUSH) && idu_valid)
                drop_q <= drop_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_flush_cnt = drop_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
